// File: rtl/lsu_pkg.sv
// Shared load/store unit types: FSM states, funct3 codes and access widths.
// Also used by main_decoder consumers that need the same funct3 meanings.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    W_BYTE    = 2'd0,
    W_HALF    = 2'd1,
    W_WORD    = 2'd2,
    W_ILLEGAL = 2'd3
  } lsu_width_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic lsu_width_e decode_width(input logic [2:0] f3, input logic store);
    lsu_width_e w;
    w = W_ILLEGAL;
    if (store) begin
      case (f3)
        F3_SB:   w = W_BYTE;
        F3_SH:   w = W_HALF;
        F3_SW:   w = W_WORD;
        default: w = W_ILLEGAL;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: w = W_BYTE;
        F3_LH, F3_LHU: w = W_HALF;
        F3_LW:         w = W_WORD;
        default:       w = W_ILLEGAL;
      endcase
    end
    return w;
  endfunction

  // Illegal width counts as a bad access so both cases share the same early-done path.
  function automatic logic access_bad(input lsu_width_e w, input logic [1:0] addr_lo);
    logic bad;
    case (w)
      W_BYTE:  bad = 1'b0;
      W_HALF:  bad = addr_lo[0];
      W_WORD:  bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store data replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_width_e       i_width,
  input  logic             i_unsigned,
  input  logic [1:0]       i_addr_lo,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [3:0]       o_be,
  output logic [XLEN-1:0]  o_wdata,
  output logic [XLEN-1:0]  o_rdata
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = i_wdata;
    o_rdata = '0;
    case (i_width)
      W_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {(XLEN/8){i_wdata[7:0]}};
        o_rdata = {{(XLEN-8){~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      end
      W_HALF: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {(XLEN/16){i_wdata[15:0]}};
        o_rdata = {{(XLEN-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      end
      W_WORD: begin
        o_be    = 4'b1111;
        o_rdata = i_rdata;
      end
      default: begin
        o_be    = 4'b0000;
        o_rdata = '0;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> (WAIT_R) -> DONE.
// Define LSU_TIMEOUT_EN to bound WAIT_R by TO_CYCLES and report err_o on expiry.
// Handshake: a request is taken when valid_i & ready_o at a rising edge; the memory
// request is held with stable attributes until mem_gnt_i is sampled high.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       mem_w_i,
  input  logic [3:0]       reg_w_i,
  input  logic [XLEN-1:0]  addr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [4:0]       rd_i,
  output logic             done_o,
  output logic [XLEN-1:0]  rdata_o,
  output logic [4:0]       rd_o,
  output logic             rd_we_o,
  output logic             misalign_o,
  output logic             err_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [XLEN-1:0]  mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [XLEN-1:0]  mem_wdata_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [XLEN-1:0]  mem_rdata_i
);

  lsu_state_e      r_state;
  logic [XLEN-1:0] r_addr, r_wdata, r_rdata;
  logic [2:0]      r_f3;
  logic [4:0]      r_rd;
  logic            r_store, r_rwe, r_done, r_rd_we, r_mis;

  lsu_width_e      w_in_width, w_width;
  logic            w_in_bad, w_req;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_st_data, w_ld_data;

  assign w_in_width = decode_width(mem_w_i[3:1], mem_w_i[0]);
  assign w_in_bad   = access_bad(w_in_width, addr_i[1:0]);
  assign w_width    = decode_width(r_f3, r_store);
  assign w_req      = (r_state == S_REQ);

  lsu_align #(.XLEN(XLEN)) u_align (
    .i_width    (w_width),
    .i_unsigned (r_f3[2]),
    .i_addr_lo  (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rdata    (mem_rdata_i),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .o_rdata    (w_ld_data)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign err_o = r_err;
`else
  logic w_unused_to;
  assign w_unused_to = TO_CYCLES[0];
  assign err_o = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^reg_w_i[3:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_f3    <= '0;
      r_rd    <= '0;
      r_store <= 1'b0;
      r_rwe   <= 1'b0;
      r_done  <= 1'b0;
      r_rd_we <= 1'b0;
      r_mis   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_i) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_rd    <= rd_i;
            r_f3    <= mem_w_i[3:1];
            r_store <= mem_w_i[0];
            r_rwe   <= reg_w_i[0];
            if (w_in_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_mis   <= 1'b1;
              r_rd_we <= 1'b0;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            if (r_store) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_rd_we <= 1'b0;
            end else begin
              r_state <= S_WAIT_R;
`ifdef LSU_TIMEOUT_EN
              r_cnt   <= '0;
`endif
            end
          end
        end
        S_WAIT_R: begin
          if (mem_rvalid_i) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_rdata <= w_ld_data;
            r_rd_we <= r_rwe;
          end
`ifdef LSU_TIMEOUT_EN
          else if (r_cnt == CW'(TO_CYCLES - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_rd_we <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_rd_we <= 1'b0;
          r_mis   <= 1'b0;
          r_rdata <= '0;
`ifdef LSU_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory attributes come straight from captured state, so they cannot move while REQ waits.
  assign ready_o     = rst_n && (r_state == S_IDLE);
  assign done_o      = r_done;
  assign rdata_o     = r_rdata;
  assign rd_o        = r_rd;
  assign rd_we_o     = r_rd_we;
  assign misalign_o  = r_mis;
  assign mem_req_o   = w_req;
  assign mem_we_o    = w_req & r_store;
  assign mem_addr_o  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign mem_be_o    = w_req ? w_be : 4'b0000;
  assign mem_wdata_o = (w_req && r_store) ? w_st_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against a byte-arithmetic reference model.
// Define LSU_TIMEOUT_EN to also exercise the WAIT_R timeout path.
module tb_load_store_unit;

  localparam int XLEN = 32;
  localparam int TO   = 255;

  logic            clk, rst_n, valid_i, ready_o;
  logic [3:0]      mem_w_i, reg_w_i;
  logic [31:0]     addr_i, wdata_i, rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [4:0]      rd_i, rd_o;
  logic            done_o, rd_we_o, misalign_o, err_o;
  logic            mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]      mem_be_o;

  load_store_unit #(.XLEN(XLEN), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .mem_w_i(mem_w_i), .reg_w_i(reg_w_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rd_i(rd_i), .done_o(done_o), .rdata_o(rdata_o), .rd_o(rd_o),
    .rd_we_o(rd_we_o), .misalign_o(misalign_o), .err_o(err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_legal(input bit st, input int f3);
    if (st) return (f3 <= 2);
    return (f3 <= 2) || (f3 == 4) || (f3 == 5);
  endfunction

  function automatic int m_size(input int f3);
    if (f3 % 4 == 0) return 1;
    if (f3 % 4 == 1) return 2;
    return 4;
  endfunction

  // One transaction: drive request, play memory with gnt delay gd and rvalid delay rvd
  // (rvd < 0 means the response never comes), and check every cycle until done_o.
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdm, input logic [4:0] rd,
                        input bit rwe, input int gd, input int rvd, input bit noise);
    bit legal, mis, got_done, timed_out;
    int sz, ofs, exp_done;
    logic [31:0] e_be, e_wd, e_ld, sh;
    legal = m_legal(st, int'(f3));
    sz    = m_size(int'(f3));
    ofs   = int'(a % 4);
    mis   = !legal || (a % sz != 0);
    timed_out = !mis && !st && rvd < 0;
    e_be  = (sz == 1) ? (32'd1 << ofs) : (sz == 2) ? (32'd3 << ofs) : 32'd15;
    e_wd  = (sz == 1) ? (wd & 32'hFF) * 32'h01010101 :
            (sz == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
    sh    = rdm >> (8 * ofs);
    if (sz == 1) begin
      e_ld = sh & 32'hFF;
      if (!f3[2] && e_ld >= 128) e_ld = e_ld + 32'hFFFFFF00;
    end else if (sz == 2) begin
      e_ld = sh & 32'hFFFF;
      if (!f3[2] && e_ld >= 32768) e_ld = e_ld + 32'hFFFF0000;
    end else begin
      e_ld = rdm;
    end
    if (timed_out) e_ld = 32'h0;
    exp_done = mis ? 1 : st ? gd + 2 : timed_out ? gd + 2 + TO : gd + 3 + rvd;
    if (!mis && !st) exp_q.push_back(e_ld);

    @(negedge clk);
    chk("ready_idle", {31'd0, ready_o}, 32'd1);
    valid_i = 1'b1;
    mem_w_i = {f3, st};
    reg_w_i = {3'($urandom_range(0, 7)), rwe};
    addr_i  = a;
    wdata_i = wd;
    rd_i    = rd;
    @(posedge clk);
    #1 valid_i = 1'b0;
    got_done = 1'b0;
    for (int n = 1; n <= exp_done + 20 && !got_done; n++) begin
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req_o}, {31'd0, !mis && n <= gd + 1});
      if (mem_req_o) begin
        chk("mem_addr", mem_addr_o, a & 32'hFFFFFFFC);
        chk("mem_be", {28'd0, mem_be_o}, e_be);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, st});
        if (st) chk("mem_wdata", mem_wdata_o, e_wd);
      end
      if (done_o) begin
        got_done = 1'b1;
        chk("done_cycle", n, exp_done);
        chk("misalign", {31'd0, misalign_o}, {31'd0, mis});
        chk("rd_we", {31'd0, rd_we_o}, {31'd0, !mis && !st && rwe && !timed_out});
        chk("rd", {27'd0, rd_o}, {27'd0, rd});
        chk("err", {31'd0, err_o}, {31'd0, timed_out});
        if (!mis && !st && exp_q.size() > 0) chk("rdata", rdata_o, exp_q.pop_front());
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        valid_i = 1'b0;
      end else begin
        mem_gnt_i = !mis && (n == gd + 1);
        if (!mis && n <= gd + 1) begin
          mem_rvalid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          mem_rdata_i  = $urandom;
        end else if (!mis && !st && rvd >= 0 && n == gd + 2 + rvd) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = rdm;
        end else begin
          mem_rvalid_i = 1'b0;
          mem_rdata_i  = $urandom;
        end
        if (noise) begin
          valid_i = 1'($urandom_range(0, 1));
          mem_w_i = 4'($urandom);
          addr_i  = $urandom;
        end
      end
    end
    if (!got_done) begin
      chk("done_seen", 32'd0, 32'd1);
      exp_q.delete();
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      valid_i = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_i = 1'b0; mem_w_i = '0; reg_w_i = '0; addr_i = '0;
    wdata_i = '0; rd_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'd0, ready_o}, 32'd1);

    // directed cases
    do_txn(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 5'd1, 1'b1, 0, 0, 1'b0);
    do_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80000000, 5'd7, 1'b1, 0, 0, 1'b0);
    do_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80000000, 5'd8, 1'b1, 0, 0, 1'b0);
    do_txn(1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0, 5'd2, 1'b0, 0, 0, 1'b0);
    do_txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h12345678, 5'd3, 1'b1, 0, 0, 1'b0);
    do_txn(1'b0, 3'b010, 32'h204, 32'h0, 32'hCAFEF00D, 5'd9, 1'b1, 3, 2, 1'b1);
    do_txn(1'b1, 3'b011, 32'h200, 32'h11111111, 32'h0, 5'd4, 1'b1, 0, 0, 1'b0);
    do_txn(1'b0, 3'b101, 32'h302, 32'h0, 32'h8001FFFF, 5'd5, 1'b1, 1, 0, 1'b0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'h1000 + $urandom_range(0, 63), $urandom, $urandom,
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of WAIT_R, then a late rvalid must be ignored
    @(negedge clk);
    valid_i = 1'b1; mem_w_i = {3'b010, 1'b0}; reg_w_i = 4'b0001; addr_i = 32'h400; rd_i = 5'd10;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mem_req_o}, 32'd0);
    chk("midrst_done", {31'd0, done_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h5A5A5A5A;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("late_rvalid_done", {31'd0, done_o}, 32'd0);
      chk("late_rvalid_ready", {31'd0, ready_o}, 32'd1);
    end
    mem_rvalid_i = 1'b0;
    do_txn(1'b0, 3'b000, 32'h501, 32'h0, 32'h0000FF00, 5'd11, 1'b1, 0, 0, 1'b0);

`ifdef LSU_TIMEOUT_EN
    do_txn(1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 5'd12, 1'b1, 0, -1, 1'b0);
    do_txn(1'b1, 3'b000, 32'h601, 32'h000000AB, 32'h0, 5'd13, 1'b0, 1, 0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter XLEN, default 32: data and address width.
REQ-002 Parameter TO_CYCLES, default 255: load response timeout in cycles; only used with LSU_TIMEOUT_EN.
REQ-003 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 Ports SHALL be as listed below.
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  core request valid.
- ready_o  out  1  unit idle, request accepted when valid_i&ready_o.
- mem_w_i  in  4  {funct3, store_en} from main decoder.
- reg_w_i  in  4  {funct3, reg_write} from main decoder.
- addr_i  in  XLEN  byte address.
- wdata_i  in  XLEN  store data.
- rd_i  in  5  destination register.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  XLEN  extended load data, valid with done_o.
- rd_o  out  5  captured rd, valid with done_o.
- rd_we_o  out  1  register writeback enable, valid with done_o.
- misalign_o  out  1  misaligned/illegal access flag, valid with done_o.
- err_o  out  1  timeout flag, valid with done_o.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  XLEN  word-aligned address (addr[1:0]=00).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  XLEN  lane-replicated store data.
- mem_gnt_i  in  1  request granted.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  XLEN  load data.

Function
REQ-005 FSM states SHALL be IDLE, REQ, WAIT_R, DONE; ready_o=1 only in IDLE.
REQ-006 On accept, SHALL register addr, wdata, rd, funct3 (mem_w_i[3:1]); store when mem_w_i[0]=1, else load.
REQ-007 Legal widths: load funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW; all other codes illegal.
REQ-008 Half access with addr[0]=1, word access with addr[1:0]!=0, or illegal funct3: IDLE->DONE, misalign_o=1, rd_we_o=0, no mem_req_o.
REQ-009 Legal access: IDLE->REQ; mem_req_o held high with stable addr/be/we/wdata until mem_gnt_i sampled high.
REQ-010 Store: REQ+gnt->DONE; load: REQ+gnt->WAIT_R; WAIT_R+mem_rvalid_i->DONE, rdata captured.
REQ-011 mem_rvalid_i SHALL be ignored outside WAIT_R.
REQ-012 mem_be_o: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
REQ-013 mem_wdata_o: byte replicated x4, half replicated x2, word unchanged.
REQ-014 Load data SHALL be lane-extracted by addr[1:0]; LB/LH sign-extended, LBU/LHU zero-extended.
REQ-015 DONE lasts one cycle: done_o=1, rd_we_o=reg_w_i[0]-captured & load & no error; then IDLE.
REQ-016 Minimum latency: store with immediate gnt, done_o 2 cycles after accept; load with gnt then rvalid next cycle, done_o 3 cycles after accept.
REQ-017 valid_i while not in IDLE SHALL be ignored; no queuing.

Reset
REQ-018 rst_n low SHALL force IDLE immediately; all outputs 0 except ready_o (1 once rst_n high); in-flight transaction dropped, later rvalid ignored.

Configuration
REQ-019 With LSU_TIMEOUT_EN defined: counter increments in WAIT_R; reaching TO_CYCLES without rvalid SHALL go DONE with err_o=1, rd_we_o=0, rdata_o=0.
REQ-020 Without LSU_TIMEOUT_EN: WAIT_R waits indefinitely, err_o tied 0, no counter logic.

Structure
REQ-021 Package lsu_pkg SHALL hold the state enum, load/store funct3 constants and width enum; shared with main_decoder consumers.
REQ-022 Combinational sub-module lsu_align SHALL implement byte-enable, store replication and load extract/extend.

Verification
REQ-023 SW addr 0x100 data 0xDEADBEEF, gnt immediate -> be 1111, wdata 0xDEADBEEF, done_o 2 cycles after accept.
REQ-024 LB addr 0x103, rdata 0x80000000 -> be 1000, rdata_o 0xFFFFFF80, rd_we_o=1; LBU same -> 0x00000080.
REQ-025 SH addr 0x102 data 0x1234 -> be 1100, wdata 0x12341234; LH addr 0x101 -> misalign_o=1, no mem_req_o.
REQ-026 gnt delayed 3 cycles -> mem_req_o/addr stable 4 cycles; valid_i pulses during busy ignored.
REQ-027 LW with rvalid never returning -> with LSU_TIMEOUT_EN err_o=1 after 255 WAIT_R cycles; rst_n asserted mid-WAIT_R -> IDLE, late rvalid produces no done_o.
